cdcm_word_aligner: RTL



---
 rtl/cdcm_word_aligner.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cdcm_word_aligner.sv
// Multi-lane CDCM word aligner: per-lane barrel shift of deserialised words with
// manual bitslip and an automatic training search that locks on a known idle word.
module cdcm_word_aligner #(
    parameter int              kNumLane   = 4,
    parameter int              kDevW      = 8,
    parameter int              kSelCount  = 3,
    parameter logic [kDevW-1:0] kPattern  = kDevW'(8'h1D),
    parameter int              kSlipWait  = 2,
    parameter int              kLockCount = 4
) (
    input  logic                          clkDivIn,
    input  logic                          pwrOnRst,
    input  logic [kNumLane*kDevW-1:0]     dInFromSerdes,
    input  logic [kNumLane-1:0]           bitslip,
    input  logic [kNumLane-1:0]           startAlign,
    output logic [kNumLane*kDevW-1:0]     dOutToDevice,
    output logic [kNumLane*kSelCount-1:0] selOut,
    output logic [kNumLane-1:0]           alignDone,
    output logic [kNumLane-1:0]           alignError,
    output logic                          allAligned
);

    localparam int                   kWaitW    = $clog2(kSlipWait + 1);
    localparam logic [kSelCount-1:0] kSelMax   = kSelCount'(kDevW - 1);
    localparam logic [kWaitW-1:0]    kWaitLast = kWaitW'(kSlipWait - 1);
    localparam logic [7:0]           kLockLast = 8'(kLockCount - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    generate
        for (genvar gi = 0; gi < kNumLane; gi++) begin : g_lane
            logic [kDevW-1:0]     cur_reg, prev_reg, dout_reg, dout_next;
            state_t               state_reg, state_next;
            logic [kSelCount-1:0] sel_reg, sel_next, sel_inc;
            logic [kSelCount-1:0] slip_cnt_reg, slip_cnt_next;
            logic [kWaitW-1:0]    wait_cnt_reg, wait_cnt_next;
            logic [7:0]           match_cnt_reg, match_cnt_next;
            logic                 match;
            logic                 done_c, err_c;

            // Modulo-kDevW increment: sel never holds a value >= kDevW.
            assign sel_inc = (sel_reg == kSelMax) ? '0 : sel_reg + 1'b1;
            assign match   = (dout_reg == kPattern);

            // Window of the two-word history starting s bits into prev; s=0 yields cur.
            always_comb begin
                dout_next = kDevW'({cur_reg, prev_reg} >> (kDevW - int'(sel_reg)));
            end

            always_ff @(posedge clkDivIn) begin
                if (pwrOnRst) begin
                    cur_reg       <= '0;
                    prev_reg      <= '0;
                    dout_reg      <= '0;
                    state_reg     <= ST_IDLE;
                    sel_reg       <= '0;
                    slip_cnt_reg  <= '0;
                    wait_cnt_reg  <= '0;
                    match_cnt_reg <= '0;
                end else begin
                    cur_reg       <= dInFromSerdes[gi*kDevW +: kDevW];
                    prev_reg      <= cur_reg;
                    dout_reg      <= dout_next;
                    state_reg     <= state_next;
                    sel_reg       <= sel_next;
                    slip_cnt_reg  <= slip_cnt_next;
                    wait_cnt_reg  <= wait_cnt_next;
                    match_cnt_reg <= match_cnt_next;
                end
            end

            always_comb begin
                state_next     = state_reg;
                sel_next       = sel_reg;
                slip_cnt_next  = slip_cnt_reg;
                wait_cnt_next  = wait_cnt_reg;
                match_cnt_next = match_cnt_reg;
                // A (re)start overrides everything, including a same-cycle bitslip.
                if (startAlign[gi]) begin
                    state_next     = ST_WAIT;
                    slip_cnt_next  = '0;
                    wait_cnt_next  = '0;
                    match_cnt_next = '0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (bitslip[gi]) begin
                                sel_next = sel_inc;
                            end
                        end
                        ST_WAIT: begin
                            if (wait_cnt_reg == kWaitLast) begin
                                state_next     = ST_CHECK;
                                match_cnt_next = '0;
                            end else begin
                                wait_cnt_next = wait_cnt_reg + 1'b1;
                            end
                        end
                        ST_CHECK: begin
                            if (match) begin
                                if (match_cnt_reg == kLockLast) begin
                                    state_next = ST_LOCKED;
                                end else begin
                                    match_cnt_next = match_cnt_reg + 8'd1;
                                end
                            end else if (slip_cnt_reg == kSelMax) begin
                                state_next = ST_FAIL;
                            end else begin
                                state_next    = ST_WAIT;
                                sel_next      = sel_inc;
                                slip_cnt_next = slip_cnt_reg + 1'b1;
                                wait_cnt_next = '0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            always_comb begin
                done_c = (state_reg == ST_LOCKED);
                err_c  = (state_reg == ST_FAIL);
            end

            assign dOutToDevice[gi*kDevW +: kDevW]     = dout_reg;
            assign selOut[gi*kSelCount +: kSelCount]   = sel_reg;
            assign alignDone[gi]                       = done_c;
            assign alignError[gi]                      = err_c;
        end
    endgenerate

    assign allAligned = &alignDone;

endmodule
